// File: rtl/decoder_scan_if.sv
// Control/status bundle between a scan sequencer client and decoder_scan_ctrl.
// E/In feed the 3-to-8 decoder directly.
interface decoder_scan_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               one_shot;
    logic [7:0]         mask;
    logic [DWELL_W-1:0] dwell;
    logic               E;
    logic [2:0]         In;
    logic               busy;
    logic               sweep_done;

    modport master (
        output start, stop, one_shot, mask, dwell,
        input  E, In, busy, sweep_done
    );

    modport slave (
        input  start, stop, one_shot, mask, dwell,
        output E, In, busy, sweep_done
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 decoder: walks the enabled channels in ascending
// order, blanking the decoder before each channel and holding it for a dwell time.
//
//  state | meaning
//  IDLE  | decoder disabled, waiting for start
//  BLANK | decoder disabled, In already points at the upcoming channel
//  DWELL | decoder enabled on channel In for captured dwell+1 cycles
module decoder_scan_ctrl #(
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 2
) (
    input logic            clk,
    input logic            rst_n,
    decoder_scan_if.slave  bus
);
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BW-1:0] BLANK_LOAD = (BLANK_CYC > 0) ? BW'(BLANK_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

    state_t             state;
    logic [BW-1:0]      blank_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               os_q;
    logic               e_q;
    logic [2:0]         in_q;
    logic               busy_q;
    logic               done_q;
    logic [2:0]         nxt_ch;
    logic               wrap;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Searching offsets high-to-low leaves the nearest set bit above cur (mod 8).
    function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
        logic [2:0] r;
        logic [2:0] idx;
        r = cur;
        for (int i = 8; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (m[idx]) r = idx;
        end
        return r;
    endfunction

    always_comb begin
        nxt_ch = next_ch(bus.mask, in_q);
        wrap   = (nxt_ch <= in_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            blank_cnt <= '0;
            dwell_cnt <= '0;
            os_q      <= 1'b0;
            e_q       <= 1'b0;
            in_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop && (bus.mask != 8'h00)) begin
                        os_q   <= bus.one_shot;
                        in_q   <= lowest_ch(bus.mask);
                        busy_q <= 1'b1;
                        if (BLANK_CYC == 0) begin
                            state     <= DWELL;
                            e_q       <= 1'b1;
                            dwell_cnt <= bus.dwell;
                        end else begin
                            state     <= BLANK;
                            blank_cnt <= BLANK_LOAD;
                        end
                    end
                end
                BLANK: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (blank_cnt == '0) begin
                        state     <= DWELL;
                        e_q       <= 1'b1;
                        dwell_cnt <= bus.dwell;
                    end else begin
                        blank_cnt <= blank_cnt - 1'b1;
                    end
                end
                DWELL: begin
                    if (bus.stop) begin
                        state  <= IDLE;
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end else if (dwell_cnt != '0) begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end else if (bus.mask == 8'h00) begin
                        state  <= IDLE;
                        e_q    <= 1'b0;
                        busy_q <= 1'b0;
                    end else begin
                        done_q <= wrap;
                        if (wrap && os_q) begin
                            // Finished single sweep: In keeps the last channel scanned.
                            state  <= IDLE;
                            e_q    <= 1'b0;
                            busy_q <= 1'b0;
                        end else if (BLANK_CYC == 0) begin
                            in_q      <= nxt_ch;
                            dwell_cnt <= bus.dwell;
                        end else begin
                            state     <= BLANK;
                            e_q       <= 1'b0;
                            in_q      <= nxt_ch;
                            blank_cnt <= BLANK_LOAD;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    e_q    <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.E          = e_q;
    assign bus.In         = in_q;
    assign bus.busy       = busy_q;
    assign bus.sweep_done = done_q;
endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: expected enable-rise and sweep_done
// events are queued at stimulus time and matched as the DUT produces them.
module tb_decoder_scan_ctrl;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total  = 0;
    int   passed = 0;
    logic mon_en = 1'b1;
    logic e_prev = 1'b0;

    int exp_rise_cyc[$];
    int exp_rise_ch[$];
    int exp_done[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decoder_scan_if #(.DWELL_W(DW)) bus  ();
    decoder_scan_if #(.DWELL_W(DW)) bus0 ();

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    decoder_scan_ctrl #(.DWELL_W(DW), .BLANK_CYC(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard consumer: every E rise and every sweep_done must match a queued event.
    always @(negedge clk) begin
        int c;
        int ch;
        if (mon_en) begin
            if (bus.E === 1'b1 && e_prev === 1'b0) begin
                if (exp_rise_cyc.size() == 0) begin
                    total++;
                    $error("FAIL unexpected_rise: observed rise at cycle %0d ch %0d expected none", cyc, bus.In);
                end else begin
                    c  = exp_rise_cyc.pop_front();
                    ch = exp_rise_ch.pop_front();
                    check("rise_cycle", cyc, c);
                    check("rise_ch", bus.In, ch);
                end
            end
            if (bus.sweep_done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    total++;
                    $error("FAIL unexpected_done: observed pulse at cycle %0d expected none", cyc);
                end else begin
                    c = exp_done.pop_front();
                    check("done_cycle", cyc, c);
                end
            end
        end
        e_prev = bus.E;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ks;
        int chs[3];
        bus.start = 0;  bus.stop = 0;  bus.one_shot = 0;  bus.mask = 0;  bus.dwell = 0;
        bus0.start = 0; bus0.stop = 0; bus0.one_shot = 0; bus0.mask = 0; bus0.dwell = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_E", bus.E, 0);
        check("rst_In", bus.In, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.sweep_done, 0);

        // start with empty mask is ignored
        bus.start = 1; bus.mask = 8'h00; bus.one_shot = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (3) @(negedge clk);
        check("mask0_busy", bus.busy, 0);

        // stop wins over start in IDLE
        bus.start = 1; bus.stop = 1; bus.mask = 8'hFF;
        @(negedge clk);
        bus.start = 0; bus.stop = 0;
        check("stop_start_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("stop_start_busy2", bus.busy, 0);

        // one-shot full sweep: period 6, 8 channels
        bus.dwell = 8'd3; bus.mask = 8'hFF; bus.one_shot = 1;
        ks = cyc + 1;
        for (int j = 0; j < 8; j++) begin
            exp_rise_cyc.push_back(ks + j * 6 + 2);
            exp_rise_ch.push_back(j);
        end
        exp_done.push_back(ks + 48);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        check("os_busy", bus.busy, 1);
        check("os_first_In", bus.In, 0);
        check("os_first_E", bus.E, 0);
        wait_until(ks + 6);
        check("os_fall_E", bus.E, 0);
        check("os_fall_In", bus.In, 1);
        wait_until(ks + 47);
        check("os_last_E", bus.E, 1);
        check("os_last_busy", bus.busy, 1);
        wait_until(ks + 48);
        check("os_end_done", bus.sweep_done, 1);
        check("os_end_busy", bus.busy, 0);
        check("os_end_In", bus.In, 7);
        check("os_end_E", bus.E, 0);
        repeat (10) @(negedge clk);
        check("os_idle_busy", bus.busy, 0);
        check("os_rise_q", exp_rise_cyc.size(), 0);
        check("os_done_q", exp_done.size(), 0);

        // masked continuous, dwell 0: 2,5,7 repeating, stop on a completing cycle
        chs[0] = 2; chs[1] = 5; chs[2] = 7;
        bus.dwell = 8'd0; bus.mask = 8'b1010_0100; bus.one_shot = 0;
        ks = cyc + 1;
        for (int j = 0; j < 12; j++) begin
            exp_rise_cyc.push_back(ks + j * 3 + 2);
            exp_rise_ch.push_back(chs[j % 3]);
        end
        for (int s = 1; s <= 3; s++) exp_done.push_back(ks + 9 * s);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        check("cont_first_In", bus.In, 2);
        wait_until(ks + 35);
        bus.stop = 1;
        @(negedge clk);
        bus.stop = 0;
        check("cont_stop_E", bus.E, 0);
        check("cont_stop_busy", bus.busy, 0);
        check("cont_stop_done", bus.sweep_done, 0);
        check("cont_stop_In", bus.In, 7);
        repeat (6) @(negedge clk);
        check("cont_rise_q", exp_rise_cyc.size(), 0);
        check("cont_done_q", exp_done.size(), 0);

        // single channel, then mask cleared mid-dwell
        bus.dwell = 8'd1; bus.mask = 8'h10; bus.one_shot = 0;
        ks = cyc + 1;
        for (int j = 0; j < 5; j++) begin
            exp_rise_cyc.push_back(ks + j * 4 + 2);
            exp_rise_ch.push_back(4);
        end
        for (int j = 1; j <= 4; j++) exp_done.push_back(ks + 4 * j);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_until(ks + 18);
        check("single_mid_E", bus.E, 1);
        bus.mask = 8'h00;
        wait_until(ks + 19);
        check("single_hold_E", bus.E, 1);
        wait_until(ks + 20);
        check("clr_busy", bus.busy, 0);
        check("clr_E", bus.E, 0);
        check("clr_In", bus.In, 4);
        repeat (6) @(negedge clk);
        check("single_rise_q", exp_rise_cyc.size(), 0);
        check("single_done_q", exp_done.size(), 0);

        // all-ones dwell: 256-cycle enable
        bus.dwell = 8'hFF; bus.mask = 8'h01; bus.one_shot = 1;
        ks = cyc + 1;
        exp_rise_cyc.push_back(ks + 2);
        exp_rise_ch.push_back(0);
        exp_done.push_back(ks + 258);
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_until(ks + 257);
        check("maxdw_last_E", bus.E, 1);
        wait_until(ks + 258);
        check("maxdw_end_E", bus.E, 0);
        check("maxdw_end_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        check("maxdw_rise_q", exp_rise_cyc.size(), 0);
        check("maxdw_done_q", exp_done.size(), 0);

        // BLANK_CYC=0 build: E stays high across channel changes
        bus0.dwell = 8'd1; bus0.mask = 8'b0000_0111; bus0.one_shot = 1;
        ks = cyc + 1;
        bus0.start = 1;
        @(negedge clk);
        bus0.start = 0;
        for (int j = 0; j < 6; j++) begin
            wait_until(ks + j);
            check("nb_E_high", bus0.E, 1);
            check("nb_In", bus0.In, j / 2);
        end
        wait_until(ks + 6);
        check("nb_done", bus0.sweep_done, 1);
        check("nb_busy", bus0.busy, 0);
        check("nb_E_end", bus0.E, 0);
        check("nb_In_end", bus0.In, 2);

        // asynchronous reset mid-dwell
        mon_en = 1'b0;
        bus.dwell = 8'd5; bus.mask = 8'hFF; bus.one_shot = 0;
        ks = cyc + 1;
        bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        wait_until(ks + 4);
        check("ar_pre_E", bus.E, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_E", bus.E, 0);
        check("ar_busy", bus.busy, 0);
        check("ar_In", bus.In, 0);
        @(negedge clk);
        check("ar_done", bus.sweep_done, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("ar_idle_busy", bus.busy, 0);
        check("ar_idle_E", bus.E, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
